// File: rtl/taxi_dma_psdpram_seg.sv
`timescale 1ns/1ps
// Segmented simple-dual-port DMA RAM: per-segment byte-enable write port and pipelined,
// credit-flow-controlled read port. Optional macro TAXI_DMA_RAM_WR_FWD_EN forwards same-cycle write data.
module taxi_dma_psdpram_seg #(
    parameter int unsigned SEGS       = 2,
    parameter int unsigned SEG_ADDR_W = 10,
    parameter int unsigned SEG_DATA_W = 128,
    parameter int unsigned SEG_BE_W   = SEG_DATA_W / 8,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned PIPELINE   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SEGS*SEL_W-1:0]        wr_cmd_sel,
    input  logic [SEGS*SEG_ADDR_W-1:0]   wr_cmd_addr,
    input  logic [SEGS*SEG_DATA_W-1:0]   wr_cmd_data,
    input  logic [SEGS*SEG_BE_W-1:0]     wr_cmd_be,
    input  logic [SEGS-1:0]              wr_cmd_valid,
    output logic [SEGS-1:0]              wr_cmd_ready,
    output logic [SEGS-1:0]              wr_done,
    input  logic [SEGS*SEL_W-1:0]        rd_cmd_sel,
    input  logic [SEGS*SEG_ADDR_W-1:0]   rd_cmd_addr,
    input  logic [SEGS-1:0]              rd_cmd_valid,
    output logic [SEGS-1:0]              rd_cmd_ready,
    output logic [SEGS*SEG_DATA_W-1:0]   rd_resp_data,
    output logic [SEGS-1:0]              rd_resp_valid,
    input  logic [SEGS-1:0]              rd_resp_ready
);
    localparam int unsigned RAM_DEPTH = 1 << SEG_ADDR_W;
    localparam int unsigned FIFO_D    = PIPELINE + 1;
    localparam int unsigned PTR_W     = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_D + 1);

    logic unused_sel;
    assign unused_sel = ^{wr_cmd_sel, rd_cmd_sel};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    for (genvar s = 0; s < SEGS; s++) begin : g_seg
        logic [SEG_ADDR_W-1:0] wr_addr;
        logic [SEG_ADDR_W-1:0] rd_addr;
        logic [SEG_DATA_W-1:0] wr_data;
        logic [SEG_BE_W-1:0]   wr_be;
        logic [SEG_DATA_W-1:0] rd_word;
        logic                  wr_rdy_q;
        logic                  rd_rdy_q;
        logic                  wr_done_q;
        logic                  wr_fire;
        logic                  rd_fire;
        logic                  fifo_empty;
        logic                  last_valid;
        logic                  resp_valid;
        logic                  pop;
        logic                  fifo_pop;
        logic                  push;
        logic [SEG_DATA_W-1:0] resp_data;
        logic [SEG_DATA_W-1:0] mem [RAM_DEPTH];
        logic [SEG_DATA_W-1:0] pipe_data [PIPELINE];
        logic [PIPELINE-1:0]   pipe_valid;
        logic [SEG_DATA_W-1:0] fifo_mem [FIFO_D];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      fifo_cnt;
        logic [CNT_W-1:0]      fifo_cnt_next;
        logic [CNT_W-1:0]      outstanding;
        logic [CNT_W-1:0]      outstanding_next;

        assign wr_addr = wr_cmd_addr[s*SEG_ADDR_W +: SEG_ADDR_W];
        assign rd_addr = rd_cmd_addr[s*SEG_ADDR_W +: SEG_ADDR_W];
        assign wr_data = wr_cmd_data[s*SEG_DATA_W +: SEG_DATA_W];
        assign wr_be   = wr_cmd_be[s*SEG_BE_W +: SEG_BE_W];
        assign wr_fire = wr_cmd_valid[s] & wr_rdy_q;
        assign rd_fire = rd_cmd_valid[s] & rd_rdy_q;

        // Byte-masked RAM write; contents are intentionally not reset.
        always_ff @(posedge clk) begin
            for (int unsigned b = 0; b < SEG_BE_W; b++) begin
                if (wr_fire && wr_be[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end

        always_comb begin
            rd_word = mem[rd_addr];
`ifdef TAXI_DMA_RAM_WR_FWD_EN
            if (wr_fire && (wr_addr == rd_addr)) begin
                for (int unsigned b = 0; b < SEG_BE_W; b++) begin
                    if (wr_be[b]) begin
                        rd_word[b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
`endif
        end

        // Read data shift pipe and response FIFO storage (data only, no reset needed).
        always_ff @(posedge clk) begin
            pipe_data[0] <= rd_word;
            for (int unsigned i = 1; i < PIPELINE; i++) begin
                pipe_data[i] <= pipe_data[i-1];
            end
            if (push) begin
                fifo_mem[wr_ptr] <= pipe_data[PIPELINE-1];
            end
        end

        // Pipe tail bypasses an empty FIFO so an unstalled response costs no extra cycle.
        always_comb begin
            fifo_empty = (fifo_cnt == '0);
            last_valid = pipe_valid[PIPELINE-1];
            resp_valid = !fifo_empty || last_valid;
            resp_data  = '0;
            if (!fifo_empty) begin
                resp_data = fifo_mem[rd_ptr];
            end else if (last_valid) begin
                resp_data = pipe_data[PIPELINE-1];
            end
            pop              = resp_valid && rd_resp_ready[s];
            fifo_pop         = pop && !fifo_empty;
            push             = last_valid && !(fifo_empty && pop);
            fifo_cnt_next    = fifo_cnt + CNT_W'(push) - CNT_W'(fifo_pop);
            outstanding_next = outstanding + CNT_W'(rd_fire) - CNT_W'(pop);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_rdy_q    <= 1'b0;
                rd_rdy_q    <= 1'b0;
                wr_done_q   <= 1'b0;
                pipe_valid  <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                fifo_cnt    <= '0;
                outstanding <= '0;
            end else begin
                wr_rdy_q    <= 1'b1;
                wr_done_q   <= wr_fire;
                pipe_valid  <= PIPELINE'({pipe_valid, rd_fire});
                fifo_cnt    <= fifo_cnt_next;
                outstanding <= outstanding_next;
                rd_rdy_q    <= (outstanding_next < CNT_W'(FIFO_D));
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (fifo_pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
            end
        end

        assign wr_cmd_ready[s]                            = wr_rdy_q;
        assign wr_done[s]                                 = wr_done_q;
        assign rd_cmd_ready[s]                            = rd_rdy_q;
        assign rd_resp_valid[s]                           = resp_valid;
        assign rd_resp_data[s*SEG_DATA_W +: SEG_DATA_W]   = resp_data;
    end

endmodule
